// File: rtl/bcd_pkg.sv
// Shared types and elaboration helpers for the serial binary-to-BCD converter.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Decimal digits needed for the largest magnitude a width/signedness can produce.
    function automatic int min_bcd_digits(input int width, input int is_signed);
        logic [63:0] m;
        int          d;
        m = (is_signed != 0) ? (64'd1 << (width - 1)) : ((64'd1 << width) - 64'd1);
        d = 1;
        while (m >= 64'd10) begin
            m = m / 64'd10;
            d++;
        end
        return d;
    endfunction

endpackage

// File: rtl/bcd_digit_adjust.sv
// Double-dabble correction cell: add 3 to a BCD digit that is 5 or more.
module bcd_digit_adjust (
    input  logic [3:0] din,
    output logic [3:0] dout
);

    assign dout = (din >= 4'd5) ? din + 4'd3 : din;

endmodule

// File: rtl/binary_to_bcd_serial.sv
// Serial (one bit per cycle) double-dabble converter with valid/ready handshakes
// on both sides; optional two's-complement input reported as sign + magnitude.
module binary_to_bcd_serial
    import bcd_pkg::*;
#(
    parameter int BIN_W  = 16,
    parameter int DIGITS = 5,
    parameter int SIGNED = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [BIN_W-1:0]      in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   out_bcd,
    output logic                  out_neg,
    output logic                  busy
);

    localparam int CNT_W = $clog2(BIN_W + 1);

    if (BIN_W < 4 || BIN_W > 32) begin : g_bad_width
        $fatal(1, "binary_to_bcd_serial: BIN_W out of range 4..32");
    end
    if (DIGITS < min_bcd_digits(BIN_W, SIGNED)) begin : g_bad_digits
        $fatal(1, "binary_to_bcd_serial: DIGITS too small for BIN_W");
    end

    state_t               state, state_nxt;
    logic [BIN_W-1:0]     mag, in_mag;
    logic [4*DIGITS-1:0]  acc, acc_adj;
    logic [CNT_W-1:0]     cnt;
    logic                 neg, in_neg, accept, last;

    for (genvar i = 0; i < DIGITS; i++) begin : g_dig
        bcd_digit_adjust u_adj (
            .din  (acc[4*i +: 4]),
            .dout (acc_adj[4*i +: 4])
        );
    end

    // -2^(BIN_W-1) negates to itself, which read unsigned is the right magnitude.
    assign in_neg   = (SIGNED != 0) && in_data[BIN_W-1];
    assign in_mag   = in_neg ? (~in_data + 1'b1) : in_data;

    assign in_ready = (state == IDLE) || ((state == DONE) && out_ready);
    assign accept   = in_valid && in_ready;
    assign last     = (cnt == CNT_W'(BIN_W - 1));

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = SHIFT;
            SHIFT:   if (last) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = in_valid ? SHIFT : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            mag   <= '0;
            acc   <= '0;
            cnt   <= '0;
            neg   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                mag <= in_mag;
                neg <= in_neg;
                acc <= '0;
                cnt <= '0;
            end else if (state == SHIFT) begin
                {acc, mag} <= {acc_adj, mag} << 1;
                cnt        <= cnt + CNT_W'(1);
            end
        end
    end

    assign out_bcd   = acc;
    assign out_neg   = neg;
    assign out_valid = (state == DONE);
    assign busy      = (state == SHIFT);

endmodule
